mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the MAR/MDR datapath: the other end of the MDR's memory load path.
- Accepts read/write requests from the CPU control unit, addressed by MAR and carrying MDR write data.
- Drives MDataIn back to the MDR after a configurable number of wait states.
- Completes each access with a four-phase ready handshake; stands in for main memory in the bus-architecture datapath.

Parameters:
- BITS, 32, data word width; matches MDR/bus width.
- ADDR_BITS, 9, address width taken from MAR.
- DEPTH, 512, number of words in the array; must be <= 2**ADDR_BITS.
- WAIT_CYCLES, 2, wait states inserted before an access commits; legal range 0..15.

Ports:
- clk  input  1  system clock; rising-edge.
- clear  input  1  asynchronous, active-low reset.
- addr  input  ADDR_BITS  word address from MAR.
- MDRout  input  BITS  write data from MDR.
- read  input  1  read request, level.
- write  input  1  write request, level.
- MDataIn  output  BITS  read data to MDR.
- ready  output  1  access complete.
- busy  output  1  access in progress.
- addr_err  output  1  out-of-range access flag; only meaningful with ADDR_CHECK_EN.

Behaviour:
- Reset (clear=0, asynchronous):
  - State=IDLE; MDataIn=0, ready=0, busy=0, addr_err=0, wait counter=0.
  - Memory array is NOT cleared.
  - Reset during WAIT aborts the access: a pending write is discarded and the array is unchanged.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On a rising edge with exactly one of read/write high: latch addr, MDRout and the op; load counter=WAIT_CYCLES; go to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - read=write=1: illegal request, ignored; remain in IDLE with no outputs changed.
- WAIT:
  - busy=1; counter decrements each cycle; counter reaching 1 -> ACCESS.
  - addr/MDRout/read/write changes are ignored because the values are latched.
- ACCESS (one cycle, busy=1):
  - Write: mem[latched addr] <= latched data.
  - Read: MDataIn <= mem[latched addr].
  - Next state DONE.
- DONE:
  - ready=1, busy=0.
  - Remain in DONE while the request that started the access stays high.
  - Requester deasserts read and write -> IDLE next edge, ready=0.
- Latency: request sampled at edge N gives ready=1 after edge N+WAIT_CYCLES+1 (ACCESS counts as one cycle).
- MDataIn:
  - Registered; holds the last read value until the next read commits.
  - Write accesses do not alter MDataIn.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Outputs ready and busy are never high simultaneously.
- Addresses >= DEPTH without ADDR_CHECK_EN: index wraps modulo DEPTH (low bits used when DEPTH is a power of two).

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - Latched address >= DEPTH: in ACCESS the write is suppressed, or MDataIn <= 0 for a read.
  - addr_err=1 together with ready in DONE; cleared on return to IDLE.
- Not defined:
  - addr_err tied 0; address wraps as above; no suppression logic is synthesized.

Test Plan:
1. Reset, then write: clear=0 for 20ns, release; write=1, addr=5, MDRout=32'hDEADBEEF -> busy=1 for 3 cycles, ready=1 at edge N+3; drop write -> ready=0 next edge.
2. Read-back: read=1, addr=5 -> ready at N+3 with MDataIn=32'hDEADBEEF; MDataIn keeps that value after read drops; a subsequent write to addr 6 leaves MDataIn unchanged.
3. Latch check: start write addr=7 data=32'h1; during WAIT change addr=8, MDRout=32'hFFFFFFFF -> read of 7 returns 32'h1 and read of 8 is unchanged.
4. Illegal request: read=write=1 for 5 cycles -> busy=0, ready=0, state stays IDLE; a following legal read completes normally.
5. Reset mid-operation: write addr=3 data=32'hA5A5A5A5, assert clear during the first WAIT cycle -> ready=0, busy=0 immediately; read of addr 3 returns its prior value. Repeat with WAIT_CYCLES=0 -> ready at N+1.
6. MEM_ADDR_CHECK_EN with DEPTH=256: write addr=300 -> addr_err=1 with ready and no array change; read addr=300 -> MDataIn=0, addr_err=1; addr_err=0 after the handshake completes.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Word-addressed memory model that answers the MAR/MDR datapath. Accepts a
//   read or write request from the control unit, inserts WAIT_CYCLES wait
//   states, commits the access in one ACCESS cycle, then signals completion
//   with a four-phase ready handshake. Request address and data are latched
//   when the request is accepted, so later changes on the bus are ignored.
//
// Parameters
//   BITS        data word width (matches MDR / bus)
//   ADDR_BITS   address width taken from MAR
//   DEPTH       number of words, <= 2**ADDR_BITS
//   WAIT_CYCLES wait states before commit, 0..15
//
// Ports
//   clk       system clock, rising edge
//   clear     asynchronous active-low reset
//   addr      word address from MAR
//   MDRout    write data from MDR
//   read      read request (level)
//   write     write request (level)
//   MDataIn   registered read data to MDR; holds until the next read commits
//   ready     access complete (DONE)
//   busy      access in progress (WAIT / ACCESS)
//   addr_err  out-of-range access flag, valid with ready
//
// Build option
//   MEM_ADDR_CHECK_EN  when defined, accesses with latched address >= DEPTH
//                      are suppressed (write dropped, read returns 0) and
//                      flagged on addr_err. When undefined, addr_err is tied
//                      low and the address wraps modulo DEPTH.
//
// State table
//   IDLE   | waiting for exactly one of read/write
//   WAIT   | request latched, counting down wait states (busy=1)
//   ACCESS | one-cycle array read or write (busy=1)
//   DONE   | ready=1, held until read and write are both low
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int BITS        = 32,
    parameter int ADDR_BITS   = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BITS-1:0]      MDRout,
    input  logic                 read,
    input  logic                 write,
    output logic [BITS-1:0]      MDataIn,
    output logic                 ready,
    output logic                 busy,
    output logic                 addr_err
);

    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [BITS-1:0]        lat_data;
    logic                   lat_write;

    logic [BITS-1:0]        mem [DEPTH];
    logic [31:0]            addr_wide;
    logic [IDX_BITS-1:0]    idx;
    logic                   mem_we;
    logic [BITS-1:0]        rd_data;

    // Modulo keeps non-power-of-two depths in range; for power-of-two depths
    // it reduces to taking the low address bits.
    assign addr_wide = 32'(lat_addr);
    assign idx       = IDX_BITS'(addr_wide % 32'(DEPTH));

`ifdef MEM_ADDR_CHECK_EN
    logic in_range;
    assign in_range = (addr_wide < 32'(DEPTH));
    assign mem_we   = (state == ACCESS) && lat_write && in_range;
    assign rd_data  = in_range ? mem[idx] : '0;
`else
    assign mem_we   = (state == ACCESS) && lat_write;
    assign rd_data  = mem[idx];
    assign addr_err = 1'b0;
`endif

    // Array has no reset: contents survive clear. An access aborted by clear
    // never reaches ACCESS, so a pending write is simply dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= lat_data;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            MDataIn   <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            addr_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // read and write together is an illegal request: ignored.
                    if (read ^ write) begin
                        lat_addr  <= addr;
                        lat_data  <= MDRout;
                        lat_write <= write;
                        wait_cnt  <= WAIT_LOAD;
                        busy      <= 1'b1;
                        state     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!lat_write) begin
                        MDataIn <= rd_data;
                    end
`ifdef MEM_ADDR_CHECK_EN
                    addr_err <= !in_range;
`endif
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    if (!read && !write) begin
                        ready <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
                        addr_err <= 1'b0;
`endif
                        state <= IDLE;
                    end
                end

                default: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] mdr = '0;
    logic [2:0]  rd = '0;
    logic [2:0]  wr = '0;
    logic [31:0] mdi [3];
    logic [2:0]  ready;
    logic [2:0]  busy;
    logic [2:0]  aerr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // 0: WAIT_CYCLES=0, 1: defaults, 2: DEPTH=256
    mem_responder #(.BITS(32), .ADDR_BITS(9), .DEPTH(512), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .clear(clear), .addr(addr), .MDRout(mdr), .read(rd[0]), .write(wr[0]),
        .MDataIn(mdi[0]), .ready(ready[0]), .busy(busy[0]), .addr_err(aerr[0]));

    mem_responder #(.BITS(32), .ADDR_BITS(9), .DEPTH(512), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .clear(clear), .addr(addr), .MDRout(mdr), .read(rd[1]), .write(wr[1]),
        .MDataIn(mdi[1]), .ready(ready[1]), .busy(busy[1]), .addr_err(aerr[1]));

    mem_responder #(.BITS(32), .ADDR_BITS(9), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .clear(clear), .addr(addr), .MDRout(mdr), .read(rd[2]), .write(wr[2]),
        .MDataIn(mdi[2]), .ready(ready[2]), .busy(busy[2]), .addr_err(aerr[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake on instance s. lat = edges after the accepting edge until
    // ready is seen (-1 on timeout); err = addr_err sampled with ready.
    task automatic xact(input int s, input logic is_wr, input logic [8:0] a,
                        input logic [31:0] d, output int lat, output logic err);
        logic ovl;
        addr  = a;
        mdr   = d;
        rd[s] = !is_wr;
        wr[s] = is_wr;
        lat   = -1;
        err   = 1'b0;
        ovl   = 1'b0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            tick();
            if (ready[s] && busy[s]) ovl = 1'b1;
            if (ready[s]) begin
                lat = k;
                err = aerr[s];
            end
        end
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        tick();
        chk("ready_busy_exclusive", 32'(ovl), 32'd0);
        chk("ready_drops_after_release", 32'(ready[s]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic err;

        // 1. reset, then timed write
        #20;
        clear = 1'b1;
        chk("reset_ready", 32'(ready[1]), 32'd0);
        chk("reset_busy", 32'(busy[1]), 32'd0);
        chk("reset_mdatain", mdi[1], 32'd0);
        chk("reset_addr_err", 32'(aerr[1]), 32'd0);
        tick();
        addr  = 9'd5;
        mdr   = 32'hDEADBEEF;
        wr[1] = 1'b1;
        tick();
        chk("wr_busy_n0", 32'({busy[1], ready[1]}), 32'b10);
        tick();
        chk("wr_busy_n1", 32'({busy[1], ready[1]}), 32'b10);
        tick();
        chk("wr_busy_n2", 32'({busy[1], ready[1]}), 32'b10);
        tick();
        chk("wr_ready_n3", 32'({busy[1], ready[1]}), 32'b01);
        chk("wr_keeps_mdatain", mdi[1], 32'd0);
        tick();
        chk("wr_done_holds", 32'(ready[1]), 32'd1);
        wr[1] = 1'b0;
        tick();
        chk("wr_ready_drop", 32'({busy[1], ready[1]}), 32'b00);

        // 2. read-back, hold, write does not touch MDataIn
        xact(1, 1'b0, 9'd5, 32'h0, lat, err);
        chk("rd5_latency", 32'(lat), 32'd3);
        chk("rd5_data", mdi[1], 32'hDEADBEEF);
        tick();
        chk("rd5_data_hold", mdi[1], 32'hDEADBEEF);
        xact(1, 1'b1, 9'd6, 32'h12345678, lat, err);
        chk("wr6_latency", 32'(lat), 32'd3);
        chk("wr6_mdatain_unchanged", mdi[1], 32'hDEADBEEF);

        // 3. request latch
        xact(1, 1'b1, 9'd8, 32'h00000088, lat, err);
        addr  = 9'd7;
        mdr   = 32'h00000001;
        wr[1] = 1'b1;
        tick();
        addr = 9'd8;
        mdr  = 32'hFFFFFFFF;
        lat  = -1;
        for (int k = 1; k < 40 && lat < 0; k++) begin
            tick();
            if (ready[1]) lat = k;
        end
        chk("latch_wr_latency", 32'(lat), 32'd3);
        wr[1] = 1'b0;
        tick();
        xact(1, 1'b0, 9'd7, 32'h0, lat, err);
        chk("latch_rd7", mdi[1], 32'h00000001);
        xact(1, 1'b0, 9'd8, 32'h0, lat, err);
        chk("latch_rd8_unchanged", mdi[1], 32'h00000088);

        // 4. illegal request
        addr  = 9'd6;
        rd[1] = 1'b1;
        wr[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("illegal_idle", 32'({busy[1], ready[1]}), 32'b00);
        end
        chk("illegal_mdatain", mdi[1], 32'h00000088);
        rd[1] = 1'b0;
        wr[1] = 1'b0;
        tick();
        xact(1, 1'b0, 9'd6, 32'h0, lat, err);
        chk("post_illegal_latency", 32'(lat), 32'd3);
        chk("post_illegal_data", mdi[1], 32'h12345678);

        // 5. reset during WAIT discards the write
        xact(1, 1'b1, 9'd3, 32'h33333333, lat, err);
        addr  = 9'd3;
        mdr   = 32'hA5A5A5A5;
        wr[1] = 1'b1;
        tick();
        chk("abort_busy_before", 32'(busy[1]), 32'd1);
        clear = 1'b0;
        #1;
        chk("abort_ready", 32'(ready[1]), 32'd0);
        chk("abort_busy", 32'(busy[1]), 32'd0);
        chk("abort_mdatain", mdi[1], 32'd0);
        wr[1] = 1'b0;
        #2;
        clear = 1'b1;
        tick();
        xact(1, 1'b0, 9'd3, 32'h0, lat, err);
        chk("abort_rd3_prior", mdi[1], 32'h33333333);

        // WAIT_CYCLES=0
        xact(0, 1'b1, 9'd3, 32'hA5A5A5A5, lat, err);
        chk("w0_wr_latency", 32'(lat), 32'd1);
        xact(0, 1'b0, 9'd3, 32'h0, lat, err);
        chk("w0_rd_latency", 32'(lat), 32'd1);
        chk("w0_rd_data", mdi[0], 32'hA5A5A5A5);

        // 6. out-of-range handling, DEPTH=256
        xact(2, 1'b1, 9'd44, 32'h00000044, lat, err);
        xact(2, 1'b1, 9'd300, 32'h00000BAD, lat, err);
        chk("oor_wr_latency", 32'(lat), 32'd3);
`ifdef MEM_ADDR_CHECK_EN
        chk("oor_wr_err", 32'(err), 32'd1);
`else
        chk("oor_wr_err", 32'(err), 32'd0);
`endif
        chk("oor_err_cleared", 32'(aerr[2]), 32'd0);
        xact(2, 1'b0, 9'd44, 32'h0, lat, err);
`ifdef MEM_ADDR_CHECK_EN
        chk("oor_array_untouched", mdi[2], 32'h00000044);
`else
        chk("oor_wrapped_write", mdi[2], 32'h00000BAD);
`endif
        chk("in_range_err", 32'(err), 32'd0);
        xact(2, 1'b0, 9'd300, 32'h0, lat, err);
`ifdef MEM_ADDR_CHECK_EN
        chk("oor_rd_data", mdi[2], 32'd0);
        chk("oor_rd_err", 32'(err), 32'd1);
`else
        chk("oor_rd_wrap_data", mdi[2], 32'h00000BAD);
        chk("oor_rd_err", 32'(err), 32'd0);
`endif
        chk("oor_rd_err_cleared", 32'(aerr[2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
